pwm_fade_scheduler: RTL and testbench
=====================================

Name: pwm_fade_scheduler

Overview:
- Sequences the 16-channel x 4-bit PWM duty bank. Accepts a 64-bit target pattern through a valid/ready command port and drives the bank's duty bus and reload-enable strobe.
- Either applies the target at once or fades every channel toward it one LSB per step at a prescaled rate.
- Sits between the pattern source (shift register or host logic) and the PWM_FSM bank. It replaces direct wiring of the pattern and button-driven RE.

Parameters:
- CH, 16, number of PWM channels.
- UDW, 4, duty width per channel in bits. The duty bus is CH*UDW bits.
- DIV, 100000, CE-qualified cycles per fade step. Must be >= 1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- CE  in  1  clock enable for the step prescaler.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  scheduler can accept a command.
- CMD_TARGET  in  CH*UDW  target duties. Channel k is bits [k*UDW +: UDW].
- CMD_MODE  in  1  0 = fade, 1 = immediate.
- ABORT  in  1  stop the fade in progress.
- DUTY  out  CH*UDW  duty bus to the PWM bank.
- RE  out  1  one-cycle reload strobe to the PWM bank.
- BUSY  out  1  command in progress.
- DONE  out  1  one-cycle pulse on completion.

Behaviour:
- All outputs and state are registered. RST low asynchronously sets: DUTY=0, RE=0, DONE=0, BUSY=0, CMD_READY=0, prescaler=0, state=IDLE.
- CMD_READY rises on the first CLK edge after RST deasserts.
- States: IDLE, WAIT, STEP, APPLY, FINISH.
- IDLE
  - CMD_READY=1, BUSY=0.
  - CMD_VALID&&CMD_READY captures CMD_TARGET into TGT and CMD_MODE.
  - Next state is APPLY if mode=1 (with DUTY<=TGT on that edge), else WAIT.
  - CMD_READY=0 in every other state. Commands are never accepted or queued while BUSY.
- WAIT
  - Prescaler increments only on CE=1.
  - On CE=1 with prescaler==DIV-1: prescaler<=0, go to STEP.
  - When DIV=1, every CE cycle ends WAIT.
- STEP (1 cycle)
  - Each channel independently: DUTY+1 if below TGT, DUTY-1 if above, unchanged if equal.
  - Unsigned arithmetic. No wrap, no overshoot.
  - Go to APPLY.
- APPLY (1 cycle)
  - RE=1, DUTY stable and already updated.
  - If DUTY==TGT on all channels, go to FINISH, else WAIT.
- FINISH (1 cycle)
  - DONE=1, then IDLE.
  - CMD_READY is 1 on the cycle after DONE.
- Latency:
  - Immediate mode: RE 1 cycle after acceptance, DONE 2 cycles after acceptance.
  - Fade mode: number of steps equals the maximum per-channel |TGT-DUTY| (at most 2^UDW-1). Each step costs DIV CE-cycles + 2 clocks.
- Target equal to current DUTY in fade mode: one WAIT period, STEP changes nothing, one RE, DONE.
- BUSY=1 in WAIT, STEP, APPLY and FINISH.
- ABORT
  - Honoured in WAIT and STEP only. Go to IDLE and clear the prescaler.
  - DUTY keeps its current value; a step scheduled on the same edge is discarded.
  - No RE, no DONE.
  - Ignored in IDLE, APPLY and FINISH. In IDLE, ABORT together with CMD_VALID still accepts the command.
- RST low mid-fade: immediate return to reset values. DUTY drops to 0, any RE in flight is lost.

Test Plan:
- Reset/immediate: RST low then high, DIV=4. Expect DUTY=0 and CMD_READY=1 one cycle after release. Then CMD_MODE=1, TGT=64'h0123456789ABCDEF with CE tied high. Expect RE 1 cycle later with DUTY=TGT, DONE the next cycle, exactly one RE.
- Fade up: DUTY=0, DIV=4, CE=1, fade to all channels 4'h3. Expect 3 RE pulses spaced 6 clocks apart with DUTY 1,2,3 per channel, then DONE 1 cycle after the third RE.
- Mixed direction: DUTY ch0=F, ch1=0; target ch0=0, ch1=F, others equal. Expect 15 steps with ch0 decrementing and ch1 incrementing, no channel passing its target, DONE after the 15th RE.
- CE gating: DIV=4, CE high every other cycle. Expect RE spacing of 8+2 clocks. Expect no prescaler advance when CE=0.
- Abort: abort in WAIT after 2 steps of a 0->F fade. Expect DUTY frozen at 2, no further RE, no DONE, CMD_READY=1 next cycle. A CMD_VALID held during BUSY is not accepted until IDLE.
- Reset mid-fade: RST low during WAIT. Expect DUTY=0, BUSY=0, RE=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/pwm_fade_scheduler.sv
// pwm_fade_scheduler: feeds a CH-channel PWM duty bank, applying a target at once
// or fading every channel one LSB per prescaled step, with a reload strobe per update.
module pwm_fade_scheduler #(
    parameter int CH  = 16,
    parameter int UDW = 4,
    parameter int DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH*UDW-1:0] cmd_target,
    input  logic              cmd_mode,
    input  logic              abort,
    output logic [CH*UDW-1:0] duty,
    output logic              re,
    output logic              busy,
    output logic              done
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, STEP, APPLY, FINISH} state_t;

    state_t            state, nxt;
    logic [PW-1:0]     presc;
    logic [CH*UDW-1:0] tgt, stepped;
    logic              accept, tick;
    logic              ready_d, busy_d, re_d, done_d;

    assign accept = state == IDLE && cmd_valid && cmd_ready;
    assign tick   = ce && presc == PW'(DIV - 1);

    // per-channel saturating move of one LSB toward the target
    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [UDW-1:0] d, t;
        assign d = duty[g*UDW +: UDW];
        assign t = tgt[g*UDW +: UDW];
        assign stepped[g*UDW +: UDW] = d < t ? d + UDW'(1) : d > t ? d - UDW'(1) : d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            presc     <= '0;
            tgt       <= '0;
            duty      <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            re        <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt;
            presc     <= state != WAIT || abort ? '0 : ce ? (tick ? '0 : presc + 1'b1) : presc;
            tgt       <= accept ? cmd_target : tgt;
            duty      <= accept && cmd_mode ? cmd_target : state == STEP && !abort ? stepped : duty;
            cmd_ready <= ready_d;
            busy      <= busy_d;
            re        <= re_d;
            done      <= done_d;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? (cmd_mode ? APPLY : WAIT) : IDLE;
            WAIT:    nxt = abort ? IDLE : tick ? STEP : WAIT;
            STEP:    nxt = abort ? IDLE : APPLY;
            APPLY:   nxt = duty == tgt ? FINISH : WAIT;
            default: nxt = IDLE;
        endcase
    end

    // outputs are registered Moore decodes of the upcoming state
    always_comb begin
        ready_d = nxt == IDLE;
        busy_d  = nxt != IDLE;
        re_d    = nxt == APPLY;
        done_d  = nxt == FINISH;
    end
endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// tb_pwm_fade_scheduler: directed checks of immediate apply, fades, CE gating,
// abort and asynchronous reset, with hand-computed expectations.
module tb_pwm_fade_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        gate = 1'b0;
    logic        ph = 1'b0;
    logic        ce;
    logic        cmd_valid = 1'b0;
    logic        cmd_mode = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] cmd_target = '0;
    logic        cmd_ready, re, busy, done;
    logic [63:0] duty;
    int          errors = 0;
    int          checks = 0;
    int          gap;
    logic [3:0]  a, b;

    pwm_fade_scheduler #(.CH(16), .UDW(4), .DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_mode(cmd_mode), .abort(abort),
        .duty(duty), .re(re), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ph <= ~ph;
    assign ce = gate ? ph : 1'b1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_re(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick(1);
            cycles++;
        end while (!re && cycles < budget);
    endtask

    task automatic immediate(input logic [63:0] t);
        cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_target = t;
        tick(1);
        cmd_valid = 1'b0;
        tick(2);
    endtask

    task automatic start_fade(input logic [63:0] t);
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_target = t;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #1;
        chk("rst_duty", duty, 64'h0);
        chk("rst_ready", {63'h0, cmd_ready}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        tick(2);
        rst_n = 1'b1;
        chk("ready_before_edge", {63'h0, cmd_ready}, 64'h0);
        tick(1);
        chk("ready_after_release", {63'h0, cmd_ready}, 64'h1);
        chk("duty_after_release", duty, 64'h0);

        cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_target = 64'h0123456789ABCDEF;
        tick(1);
        cmd_valid = 1'b0;
        chk("imm_re", {63'h0, re}, 64'h1);
        chk("imm_duty", duty, 64'h0123456789ABCDEF);
        chk("imm_done_early", {63'h0, done}, 64'h0);
        chk("imm_ready_busy", {62'h0, cmd_ready, busy}, 64'h1);
        tick(1);
        chk("imm_re_once", {63'h0, re}, 64'h0);
        chk("imm_done", {63'h0, done}, 64'h1);
        tick(1);
        chk("imm_done_pulse", {63'h0, done}, 64'h0);
        chk("imm_ready_back", {63'h0, cmd_ready}, 64'h1);

        immediate(64'h0);
        chk("zero_duty", duty, 64'h0);
        start_fade({16{4'h3}});
        for (int i = 1; i <= 3; i++) begin
            wait_re(20, gap);
            chk($sformatf("up_gap%0d", i), 64'(gap), i == 1 ? 64'd5 : 64'd6);
            a = 4'(i);
            chk($sformatf("up_duty%0d", i), duty, {16{a}});
            chk($sformatf("up_nodone%0d", i), {63'h0, done}, 64'h0);
        end
        tick(1);
        chk("up_done", {63'h0, done}, 64'h1);
        tick(1);

        immediate(64'h3333_3333_3333_330F);
        start_fade(64'h3333_3333_3333_33F0);
        for (int i = 1; i <= 15; i++) begin
            wait_re(20, gap);
            chk($sformatf("mix_gap%0d", i), 64'(gap), i == 1 ? 64'd5 : 64'd6);
            a = 4'(i);
            b = 4'(15 - i);
            chk($sformatf("mix_duty%0d", i), duty, {56'h33_3333_3333_3333, a, b});
        end
        tick(1);
        chk("mix_done", {63'h0, done}, 64'h1);
        tick(1);

        immediate(64'h0);
        gate = 1'b1;
        start_fade(64'h3);
        for (int i = 1; i <= 3; i++) begin
            wait_re(30, gap);
            if (i > 1) chk($sformatf("ce_gap%0d", i), 64'(gap), 64'd10);
            chk($sformatf("ce_duty%0d", i), duty, 64'(i));
        end
        tick(1);
        chk("ce_done", {63'h0, done}, 64'h1);
        gate = 1'b0;
        tick(1);

        immediate(64'h0);
        start_fade({16{4'hF}});
        wait_re(20, gap);
        wait_re(20, gap);
        chk("ab_duty2", duty, {16{4'h2}});
        cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_target = {16{4'h5}};
        tick(2);
        chk("ab_no_accept", duty, {16{4'h2}});
        chk("ab_busy_ready", {62'h0, cmd_ready, busy}, 64'h1);
        abort = 1'b1;
        tick(1);
        chk("ab_frozen", duty, {16{4'h2}});
        chk("ab_flags", {60'h0, cmd_ready, busy, re, done}, 64'h8);
        tick(1);
        chk("ab_accept_re", {63'h0, re}, 64'h1);
        chk("ab_accept_duty", duty, {16{4'h5}});
        cmd_valid = 1'b0; abort = 1'b0;
        tick(1);
        chk("ab_accept_done", {63'h0, done}, 64'h1);
        tick(1);

        start_fade(64'h0);
        tick(3);
        chk("rf_busy", {63'h0, busy}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rf_duty", duty, 64'h0);
        chk("rf_flags", {60'h0, cmd_ready, busy, re, done}, 64'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("rf_ready", {63'h0, cmd_ready}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
